inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 redirect_valid  in  1  jal/jalr/branch target override from execute.
REQ-005 redirect_pc  in  64  target address; bits [1:0] SHALL be ignored (forced 0).
REQ-006 req_valid  out  1  instruction-memory read request.
REQ-007 req_addr  out  64  request address, word aligned.
REQ-008 req_ready  in  1  memory accepts request when high with req_valid.
REQ-009 resp_valid  in  1  read data present (single-cycle pulse).
REQ-010 resp_data  in  32  instruction word.
REQ-011 resp_err  in  1  access fault for this response.
REQ-012 inst_valid  out  1  instruction offered to decoder.
REQ-013 inst  out  32  instruction word to decoder.
REQ-014 inst_pc  out  64  address of inst.
REQ-015 inst_fault  out  1  resp_err captured with inst.
REQ-016 inst_ready  in  1  decoder/execute consumes inst when high with inst_valid.
REQ-017 fetch_cnt  out  64  count of completed inst handshakes.

Function
REQ-018 FSM states: REQ, WAIT, FULL; at most one request outstanding.
REQ-019 REQ: req_valid=1, req_addr=registered address captured on REQ entry; req_valid+req_addr SHALL stay stable until req_ready; on req_valid&req_ready -> WAIT.
REQ-020 WAIT: req_valid=0; resp_valid ignored in every other state.
REQ-021 WAIT, resp_valid, drop=0, no redirect: capture inst=resp_data, inst_pc=pc, inst_fault=resp_err -> FULL.
REQ-022 FULL: inst_valid=1, inst/inst_pc/inst_fault stable; on inst_ready: pc<=pc+4 (64-bit wrap), fetch_cnt+=1 (wrap) -> REQ.
REQ-023 Latency: req accepted cycle N, resp earliest N+1, inst_valid earliest N+2; REQ re-entered cycle after inst handshake.
REQ-024 redirect_valid, any state: pc<={redirect_pc[63:2],2'b00} next edge; redirect SHALL win over every simultaneous event.
REQ-025 Redirect in REQ (with or without req_ready): outstanding/pending request unaffected, drop<=1; state follows REQ-019.
REQ-026 Redirect in WAIT, no resp_valid: drop<=1, stay WAIT.
REQ-027 Redirect in WAIT with resp_valid: response discarded, drop<=0 -> REQ at new pc.
REQ-028 WAIT, resp_valid, drop=1, no redirect: response discarded, drop<=0 -> REQ at pc.
REQ-029 Redirect in FULL: inst_valid=0 next cycle, fetch_cnt unchanged even if inst_ready same cycle -> REQ at new pc.
REQ-030 Discarded responses SHALL never raise inst_valid or change fetch_cnt.
REQ-031 inst_fault=1 SHALL not stall; pc advances normally on handshake.

Reset
REQ-032 rst_n low SHALL immediately force: state=REQ, pc=RESET_PC, drop=0, inst=0, inst_pc=0, inst_fault=0, inst_valid=0, fetch_cnt=0.
REQ-033 req_valid SHALL be 1 with req_addr=RESET_PC in first cycle after rst_n rises.
REQ-034 Reset mid-transaction SHALL abandon outstanding request; memory must not deliver a response for it after reset.

Verification
REQ-035 Reset release, req_ready=1, resp_valid next cycle data 32'h00100093, inst_ready=1 -> inst_valid with inst=32'h00100093, inst_pc=8000_0000; next req_addr=8000_0004; fetch_cnt=1.
REQ-036 req_ready held 0 for 5 cycles -> req_valid/req_addr stable all 5; inst_ready held 0 for 3 cycles in FULL -> inst stable, fetch_cnt unchanged.
REQ-037 Redirect to 8000_0102 while in WAIT, response 32'hDEADBEEF arrives later -> response discarded, next req_addr=8000_0100, no inst_valid for DEADBEEF.
REQ-038 Redirect same cycle as resp_valid, and separately same cycle as inst_ready in FULL -> no delivery, fetch_cnt unchanged, next req_addr=target.
REQ-039 resp_err=1 on fetch at 8000_0008 -> inst_fault=1, inst_pc=8000_0008; after handshake req_addr=8000_000C, inst_fault cleared on next good fetch.
REQ-040 rst_n low while in WAIT -> outputs per REQ-032 asynchronously; after release req_addr=8000_0000.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, a single-entry instruction
// buffer toward decode, and redirects that win over every other event.
module inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        req_valid_o,
  output logic [63:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_data_i,
  input  logic        resp_err_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  output logic        inst_fault_o,
  input  logic        inst_ready_i,
  output logic [63:0] fetch_cnt_o
);

  typedef enum logic [1:0] {StReq, StWait, StFull} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] target;

  assign target = {redirect_pc_i[63:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    drop_d       = drop_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    fetch_cnt_d  = fetch_cnt_q;

    unique case (state_q)
      StReq: begin
        // A pending request keeps its address; its response is dropped later.
        if (req_ready_i) state_d = StWait;
        if (redirect_valid_i) begin
          pc_d   = target;
          drop_d = 1'b1;
        end
      end
      StWait: begin
        if (redirect_valid_i) begin
          pc_d = target;
          if (resp_valid_i) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            drop_d = 1'b1;
          end
        end else if (resp_valid_i) begin
          drop_d = 1'b0;
          if (drop_q) begin
            state_d = StReq;
          end else begin
            inst_d       = resp_data_i;
            inst_pc_d    = pc_q;
            inst_fault_d = resp_err_i;
            state_d      = StFull;
          end
        end
      end
      StFull: begin
        if (redirect_valid_i) begin
          pc_d    = target;
          state_d = StReq;
        end else if (inst_ready_i) begin
          pc_d        = pc_q + 64'd4;
          fetch_cnt_d = fetch_cnt_q + 64'd1;
          state_d     = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    // The request address is frozen at REQ entry so it stays stable until accepted.
    if (state_q != StReq && state_d == StReq) req_addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      drop_q       <= drop_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign req_valid_o  = (state_q == StReq);
  assign req_addr_o   = req_addr_q;
  assign inst_valid_o = (state_q == StFull);
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_fault_o = inst_fault_q;
  assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a memory responder plus a transaction-level pc/count model
// checked every cycle, and literal expectations at the key points of each scenario.
module tb_inst_fetch;

  localparam logic [63:0] ResetPc = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        req_valid_o;
  logic [63:0] req_addr_o;
  logic        req_ready_i;
  logic        resp_valid_i;
  logic [31:0] resp_data_i;
  logic        resp_err_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_fault_o;
  logic        inst_ready_i;
  logic [63:0] fetch_cnt_o;

  int checks = 0;
  int errors = 0;
  logic saw_db = 1'b0;

  int          resp_delay = 1;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(ResetPc)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .req_valid_o      (req_valid_o),
    .req_addr_o       (req_addr_o),
    .req_ready_i      (req_ready_i),
    .resp_valid_i     (resp_valid_i),
    .resp_data_i      (resp_data_i),
    .resp_err_i       (resp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_fault_o     (inst_fault_o),
    .inst_ready_i     (inst_ready_i),
    .fetch_cnt_o      (fetch_cnt_o)
  );

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0010_0093;
    if (a == 64'h8000_0010) return 32'hDEAD_BEEF;
    return a[31:0] ^ 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [63:0] a);
    return a == 64'h8000_0008;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: memory accepts/answers, one-cycle pulses are cleared, then the caller drives.
  task automatic step();
    logic        acc;
    logic [63:0] a;
    @(posedge clk);
    acc = rst_n && req_valid_o && req_ready_i;
    a   = req_addr_o;
    #1;
    redirect_valid_i = 1'b0;
    resp_valid_i     = 1'b0;
    resp_err_i       = 1'b0;
    resp_data_i      = '0;
    if (!rst_n) mem_cnt = 0;
    if (acc) begin
      mem_addr = a;
      mem_cnt  = resp_delay;
    end
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        resp_valid_i = 1'b1;
        resp_data_i  = mem_data(mem_addr);
        resp_err_i   = mem_err(mem_addr);
      end
    end
  endtask

  task automatic wait_inst();
    int n = 0;
    while (!inst_valid_o && n < 20) begin
      step();
      n++;
    end
    if (!inst_valid_o) chk("inst_timeout", 64'(inst_valid_o), 64'd1);
  endtask

  // Every-cycle model: next pc and handshake count from the observed redirect/handshake events.
  initial begin : compare
    logic [63:0] model_pc, model_cnt, prev_addr;
    logic        prev_rv, prev_stall;
    model_pc = ResetPc; model_cnt = '0; prev_addr = '0; prev_rv = 1'b0; prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_pc = ResetPc; model_cnt = '0; prev_rv = 1'b0; prev_stall = 1'b0;
      end else begin
        chk("fetch_cnt", fetch_cnt_o, model_cnt);
        chk("req_inst_exclusive", 64'(req_valid_o & inst_valid_o), 64'd0);
        if (prev_stall) begin
          chk("req_hold_valid", 64'(req_valid_o), 64'd1);
          chk("req_hold_addr", req_addr_o, prev_addr);
        end
        if (req_valid_o && !prev_rv) chk("req_addr_new", req_addr_o, model_pc);
        if (inst_valid_o) begin
          chk("inst_pc", inst_pc_o, model_pc);
          chk("inst_data", 64'(inst_o), 64'(mem_data(model_pc)));
          chk("inst_fault", 64'(inst_fault_o), 64'(mem_err(model_pc)));
          if (inst_o == 32'hDEAD_BEEF) saw_db = 1'b1;
        end
        prev_rv    = req_valid_o;
        prev_stall = req_valid_o && !req_ready_i;
        prev_addr  = req_addr_o;
        if (redirect_valid_i) model_pc = redirect_pc_i & ~64'h3;
        else if (inst_valid_o && inst_ready_i) begin
          model_pc  = model_pc + 64'd4;
          model_cnt = model_cnt + 64'd1;
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0; req_ready_i = 1'b0;
    resp_valid_i = 1'b0; resp_data_i = '0; resp_err_i = 1'b0; inst_ready_i = 1'b0;
    step();
    chk("rst_req_valid", 64'(req_valid_o), 64'd1);
    chk("rst_req_addr", req_addr_o, ResetPc);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_inst_pc", inst_pc_o, 64'd0);
    chk("rst_fetch_cnt", fetch_cnt_o, 64'd0);
    step();
    rst_n = 1'b1;
    chk("boot_req_valid", 64'(req_valid_o), 64'd1);
    chk("boot_req_addr", req_addr_o, 64'h8000_0000);

    // First fetch with minimum latency.
    req_ready_i = 1'b1; inst_ready_i = 1'b1;
    step();
    chk("first_not_yet", 64'(inst_valid_o), 64'd0);
    step();
    chk("first_valid", 64'(inst_valid_o), 64'd1);
    chk("first_inst", 64'(inst_o), 64'h0010_0093);
    chk("first_pc", inst_pc_o, 64'h8000_0000);
    step();
    chk("first_cnt", fetch_cnt_o, 64'd1);
    chk("second_req_addr", req_addr_o, 64'h8000_0004);

    // Request stall, then buffer stall.
    req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req_valid", 64'(req_valid_o), 64'd1);
      chk("stall_req_addr", req_addr_o, 64'h8000_0004);
    end
    req_ready_i = 1'b1; inst_ready_i = 1'b0;
    wait_inst();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_valid", 64'(inst_valid_o), 64'd1);
      chk("full_hold_pc", inst_pc_o, 64'h8000_0004);
      chk("full_hold_cnt", fetch_cnt_o, 64'd1);
    end
    inst_ready_i = 1'b1;
    step();
    chk("after_hold_cnt", fetch_cnt_o, 64'd2);

    // Faulting fetch does not stall; next good fetch clears the fault.
    wait_inst();
    chk("fault_flag", 64'(inst_fault_o), 64'd1);
    chk("fault_pc", inst_pc_o, 64'h8000_0008);
    step();
    chk("fault_next_addr", req_addr_o, 64'h8000_000C);
    wait_inst();
    chk("fault_cleared", 64'(inst_fault_o), 64'd0);
    chk("good_pc", inst_pc_o, 64'h8000_000C);
    step();

    // Redirect while waiting; late DEADBEEF response must be discarded.
    resp_delay = 3;
    step();
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0102;
    step();
    step();
    chk("late_resp_present", 64'(resp_valid_i), 64'd1);
    resp_delay = 1;
    step();
    chk("redir_req_valid", 64'(req_valid_o), 64'd1);
    chk("redir_req_addr", req_addr_o, 64'h8000_0100);
    chk("no_deadbeef", 64'(saw_db), 64'd0);

    // Redirect coincident with the response.
    step();
    chk("coinc_resp", 64'(resp_valid_i), 64'd1);
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0200;
    step();
    chk("coinc_no_inst", 64'(inst_valid_o), 64'd0);
    chk("coinc_addr", req_addr_o, 64'h8000_0200);
    chk("coinc_cnt", fetch_cnt_o, 64'd4);

    // Redirect coincident with the decoder handshake.
    inst_ready_i = 1'b0;
    wait_inst();
    inst_ready_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0300;
    step();
    chk("hs_redir_no_inst", 64'(inst_valid_o), 64'd0);
    chk("hs_redir_cnt", fetch_cnt_o, 64'd4);
    chk("hs_redir_addr", req_addr_o, 64'h8000_0300);

    // Redirect while the request is still pending keeps the pending address.
    req_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0400;
    step();
    chk("pend_addr_kept", req_addr_o, 64'h8000_0300);
    req_ready_i = 1'b1;
    wait_inst();
    chk("pend_target_pc", inst_pc_o, 64'h8000_0400);
    step();
    chk("pend_cnt", fetch_cnt_o, 64'd5);

    // Reset while waiting for a response.
    resp_delay = 5;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("mid_rst_cnt", fetch_cnt_o, 64'd0);
    chk("mid_rst_req_valid", 64'(req_valid_o), 64'd1);
    chk("mid_rst_req_addr", req_addr_o, ResetPc);
    chk("mid_rst_inst_pc", inst_pc_o, 64'd0);
    step();
    step();
    rst_n = 1'b1; resp_delay = 1;
    chk("rerun_req_addr", req_addr_o, 64'h8000_0000);
    wait_inst();
    chk("rerun_inst", 64'(inst_o), 64'h0010_0093);
    chk("rerun_pc", inst_pc_o, 64'h8000_0000);
    step();
    chk("rerun_cnt", fetch_cnt_o, 64'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
